// File: rtl/bnn_seq_classifier_if.sv
// Sample/result bundle for bnn_seq_classifier: the feeder drives features on the
// input side, the collector accepts prediction/score on the output side.
interface bnn_seq_classifier_if #(
    parameter int FEAT_CNT   = 16,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 10
);
    localparam int SCORE_BITS = $clog2(HIDDEN_CNT + 1);
    localparam int CLS_BITS   = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_valid/features come from the feeder, in_ready from the classifier;
    // out_valid/prediction/score come from the classifier and are held until out_ready.
    logic [FEAT_BITS*FEAT_CNT-1:0] features;
    logic                          in_valid;
    logic                          in_ready;
    logic [CLS_BITS-1:0]           prediction;
    logic [SCORE_BITS-1:0]         score;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output features, in_valid, out_ready,
        input  in_ready, prediction, score, out_valid
    );

    modport slave (
        input  features, in_valid, out_ready,
        output in_ready, prediction, score, out_valid
    );
endinterface

// File: rtl/bnn_seq_classifier.sv
// Sequential one-hidden-layer binarised classifier: binarise features, evaluate
// one hidden neuron per cycle, then one class score per cycle, emit the argmax.
module bnn_seq_classifier #(
    parameter int FEAT_CNT   = 16,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 10,
    parameter logic [FEAT_CNT*FEAT_BITS-1:0]   THR = {FEAT_CNT{4'd8}},
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1  = '1,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    bnn_seq_classifier_if.slave      bus,
    output logic [1:0]               state_dbg
);
    localparam int SCORE_BITS   = $clog2(HIDDEN_CNT + 1);
    localparam int CLS_BITS     = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int HID_IDX_BITS = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
    localparam int FPOP_BITS    = $clog2(FEAT_CNT + 1);

    localparam logic [HID_IDX_BITS-1:0] H_LAST     = HID_IDX_BITS'(HIDDEN_CNT - 1);
    localparam logic [CLS_BITS-1:0]     C_LAST     = CLS_BITS'(CLASS_CNT - 1);
    localparam logic [FPOP_BITS:0]      FEAT_CNT_W = (FPOP_BITS + 1)'(FEAT_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HID  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state;
    logic [FEAT_CNT-1:0]       fbit_q;
    logic [HIDDEN_CNT-1:0]     hbit_q;
    logic [HID_IDX_BITS-1:0]   h_idx;
    logic [CLS_BITS-1:0]       c_idx;
    logic [SCORE_BITS-1:0]     best_score;
    logic [CLS_BITS-1:0]       best_idx;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [CLS_BITS-1:0]       prediction_q;
    logic [SCORE_BITS-1:0]     score_q;

    logic [FEAT_CNT-1:0]       w1_rows [HIDDEN_CNT];
    logic [HIDDEN_CNT-1:0]     w2_rows [CLASS_CNT];

    logic [FEAT_CNT-1:0]       fbit_new;
    logic [FEAT_CNT-1:0]       h_agree;
    logic [FPOP_BITS-1:0]      h_pop;
    logic                      hbit_new;
    logic [HIDDEN_CNT-1:0]     c_agree;
    logic [SCORE_BITS-1:0]     c_score;
    logic                      take_new;
    logic [SCORE_BITS-1:0]     cand_score;
    logic [CLS_BITS-1:0]       cand_idx;

    for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_w1_rows
        assign w1_rows[h] = W1[h*FEAT_CNT +: FEAT_CNT];
    end

    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_w2_rows
        assign w2_rows[c] = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
    end

    always_comb begin
        fbit_new = '0;
        for (int i = 0; i < FEAT_CNT; i++) begin
            fbit_new[i] = (bus.features[i*FEAT_BITS +: FEAT_BITS] >= THR[i*FEAT_BITS +: FEAT_BITS]);
        end
    end

    // XNOR agreement count; the neuron fires when at least half the features agree.
    always_comb begin
        h_agree = ~(fbit_q ^ w1_rows[h_idx]);
        h_pop   = '0;
        for (int i = 0; i < FEAT_CNT; i++) begin
            h_pop = h_pop + FPOP_BITS'(h_agree[i]);
        end
        hbit_new = ({h_pop, 1'b0} >= FEAT_CNT_W);
    end

    always_comb begin
        c_agree = ~(hbit_q ^ w2_rows[c_idx]);
        c_score = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            c_score = c_score + SCORE_BITS'(c_agree[h]);
        end
    end

    // Strict greater-than keeps the lowest class index on ties.
    always_comb begin
        take_new   = (c_idx == '0) || (c_score > best_score);
        cand_score = take_new ? c_score : best_score;
        cand_idx   = take_new ? c_idx   : best_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            prediction_q <= '0;
            score_q      <= '0;
            fbit_q       <= '0;
            hbit_q       <= '0;
            h_idx        <= '0;
            c_idx        <= '0;
            best_score   <= '0;
            best_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        fbit_q     <= fbit_new;
                        h_idx      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= HID;
                    end
                end
                HID: begin
                    hbit_q[h_idx] <= hbit_new;
                    if (h_idx == H_LAST) begin
                        c_idx <= '0;
                        state <= OUT;
                    end else begin
                        h_idx <= h_idx + HID_IDX_BITS'(1);
                    end
                end
                OUT: begin
                    best_score <= cand_score;
                    best_idx   <= cand_idx;
                    if (c_idx == C_LAST) begin
                        prediction_q <= cand_idx;
                        score_q      <= cand_score;
                        out_valid_q  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        c_idx <= c_idx + CLS_BITS'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.prediction = prediction_q;
    assign bus.score      = score_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Randomised and directed bench for bnn_seq_classifier with a reference model
// computed from plain per-feature / per-neuron arithmetic.
module tb_bnn_seq_classifier;
    localparam int FEAT = 16;
    localparam int FB   = 4;
    localparam int HID  = 40;
    localparam int CLS  = 10;
    localparam int SB   = 6;
    localparam int CB   = 4;
    localparam int FW   = FEAT * FB;
    localparam int RW   = CB + SB;
    localparam int LAT  = HID + CLS;

    function automatic logic [FW-1:0] make_thr();
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < FEAT; i++) r[i*FB +: FB] = FB'(1 + i % 15);
        return r;
    endfunction

    // Every hidden row keeps at least 9 ones: all-0xF fires every neuron, all-0x0 none.
    function automatic logic [HID*FEAT-1:0] make_w1();
        logic [HID*FEAT-1:0] r;
        r = '1;
        for (int h = 0; h < HID; h++)
            for (int j = 0; j < h % 8; j++) r[h*FEAT + (h + j*7) % FEAT] = 1'b0;
        return r;
    endfunction

    function automatic logic [CLS*HID-1:0] make_w2();
        logic [CLS*HID-1:0] r;
        r = '0;
        r[7*HID +: HID] = '1;
        return r;
    endfunction

    localparam logic [FW-1:0]       THR_P = make_thr();
    localparam logic [HID*FEAT-1:0] W1_P  = make_w1();
    localparam logic [CLS*HID-1:0]  W2_P  = make_w2();

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    bnn_seq_classifier_if #(.FEAT_CNT(FEAT), .FEAT_BITS(FB), .HIDDEN_CNT(HID), .CLASS_CNT(CLS)) bus ();

    bnn_seq_classifier #(
        .FEAT_CNT(FEAT), .FEAT_BITS(FB), .HIDDEN_CNT(HID), .CLASS_CNT(CLS),
        .THR(THR_P), .W1(W1_P), .W2(W2_P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // clock / reset / cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // scoreboard state
    logic [RW-1:0] exp_q[$];
    int            acc_q[$];
    int            errors = 0;
    int            checks = 0;
    int            last_acc = 0;
    int            last_pred = -1;
    int            last_score = -1;
    logic          prev_ov = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model
    function automatic logic [RW-1:0] model(input logic [FW-1:0] f);
        int fb[FEAT];
        int hb[HID];
        int agree, s, best, bi;
        for (int i = 0; i < FEAT; i++) fb[i] = (int'(f[i*FB +: FB]) >= int'(THR_P[i*FB +: FB])) ? 1 : 0;
        for (int h = 0; h < HID; h++) begin
            agree = 0;
            for (int i = 0; i < FEAT; i++) if (fb[i] == int'(W1_P[h*FEAT + i])) agree++;
            hb[h] = (2 * agree >= FEAT) ? 1 : 0;
        end
        best = 0;
        bi   = 0;
        for (int c = 0; c < CLS; c++) begin
            s = 0;
            for (int h = 0; h < HID; h++) if (hb[h] == int'(W2_P[c*HID + h])) s++;
            if (c == 0 || s > best) begin
                best = s;
                bi   = c;
            end
        end
        return {CB'(bi), SB'(best)};
    endfunction

    // monitor: each rising out_valid pops one expectation
    always @(negedge clk) begin
        logic [RW-1:0] e;
        int            a;
        if (rst && bus.out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("prediction", int'(bus.prediction), int'(e[RW-1:SB]));
                check("score", int'(bus.score), int'(e[SB-1:0]));
                check("latency", cyc - a, LAT);
                last_pred  = int'(bus.prediction);
                last_score = int'(bus.score);
            end
        end
        prev_ov = rst ? bus.out_valid : 1'b0;
    end

    always @(negedge clk) begin
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // driver tasks
    task automatic send(input logic [FW-1:0] f);
        int n = 0;
        @(negedge clk);
        bus.features = f;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(f));
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.features = {$urandom, $urandom};
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        exp_q.delete();
        acc_q.delete();
        rst = 1'b1;
    endtask

    function automatic logic [FW-1:0] fill(input logic [FB-1:0] v);
        logic [FW-1:0] r;
        for (int i = 0; i < FEAT; i++) r[i*FB +: FB] = v;
        return r;
    endfunction

    initial begin
        logic [FW-1:0] f;
        int            a1;
        int            n;

        // reset holds with in_valid asserted
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.features  = fill(4'hF);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_prediction", int'(bus.prediction), 0);
        check("rst_score", int'(bus.score), 0);
        check("rst_state", int'(state_dbg), 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(bus.in_ready), 1);

        // all hidden bits fire, class 7 wins with full score
        send(fill(4'hF));
        wait_drain();
        check("all_f_pred", last_pred, 7);
        check("all_f_score", last_score, HID);

        // result held while collector stalls, new sample ignored
        bus.out_ready = 1'b0;
        send(fill(4'hF));
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            bus.features = fill(4'h0);
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("stall_in_ready", int'(bus.in_ready), 0);
            check("stall_valid_hold", int'(bus.out_valid), 1);
            check("stall_pred_hold", int'(bus.prediction), 7);
            check("stall_score_hold", int'(bus.score), HID);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", int'(bus.out_valid), 0);
        check("release_in_ready", int'(bus.in_ready), 1);
        check("release_state", int'(state_dbg), 0);
        check("release_pred_kept", int'(bus.prediction), 7);

        // abort mid-hidden-layer, then a fresh sample
        send(fill(4'hF));
        repeat (20) @(negedge clk);
        pulse_reset(1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_score_clr", int'(bus.score), 0);
        send(fill(4'h0));
        wait_drain();
        check("fresh_pred", last_pred, 0);
        check("fresh_score", last_score, HID);

        // back-to-back samples
        send(fill(4'hF));
        a1 = last_acc;
        send(fill(4'h0));
        check("b2b_accept_gap", last_acc - a1, LAT + 2);
        wait_drain();
        check("b2b_second_pred", last_pred, 0);
        check("b2b_second_score", last_score, HID);

        // randomised samples with a random collector
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int i = 0; i < FEAT; i++) f[i*FB +: FB] = FB'($urandom_range(0, 15));
            send(f);
        end
        wait_drain();
        rand_ready = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
